dmem_ctrl: RTL and testbench

- Data-memory controller directly downstream of the core's MEM stage.
- Consumes the core's load/store request handshake (write data, valid, wen, byte_not_word, yumi, plus a 32-bit address) and produces its response handshake (yumi, valid, read_data).
- Fronts a word-organised on-chip data array with a configurable fixed access latency. Supports LW/SW and LBU/SB with little-endian byte lanes.

---
 rtl/dmem_ctrl.sv | 101 ++++++++++
 tb/tb_dmem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller behind the MEM stage: word/byte load-store into an on-chip
// word array with a fixed, parameterised response latency and a sticky range error.
module dmem_ctrl #(
  parameter int ADDR_WIDTH_P = 10,
  parameter int LATENCY_P    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_wen_i,
  input  logic        req_byte_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_yumi_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  input  logic        resp_yumi_i,
  output logic        err_o
);
  localparam int WORDS = 1 << ADDR_WIDTH_P;
  localparam logic [3:0] CNT_INIT = (LATENCY_P > 0) ? 4'(LATENCY_P - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic                    wen;
    logic                    byte_op;
    logic                    oor;
    logic [ADDR_WIDTH_P-1:0] idx;
    logic [1:0]              lane;
  } req_t;

  state_e      state, state_n;
  logic [3:0]  cnt;
  req_t        cur, lat, rd;
  logic [31:0] mem [WORDS];
  logic [31:0] rd_word, rd_val;

  assign cur = {req_wen_i, req_byte_i, |req_addr_i[31:ADDR_WIDTH_P+2],
                req_addr_i[ADDR_WIDTH_P+1:2], req_addr_i[1:0]};

  // With zero latency RESP is entered on the accept edge, so the read must use
  // the live request rather than the not-yet-latched copy.
  assign rd      = (state == IDLE) ? cur : lat;
  assign rd_word = mem[rd.idx];

  always_comb begin
    rd_val = '0;
    if (!rd.wen && !rd.oor)
      rd_val = rd.byte_op ? {24'h0, rd_word[{rd.lane, 3'b000} +: 8]} : rd_word;
  end

  always_comb begin
    state_n    = state;
    req_yumi_o = 1'b0;
    case (state)
      IDLE: if (req_valid_i) begin
        req_yumi_o = 1'b1;
        state_n    = (LATENCY_P == 0) ? RESP : WAIT;
      end
      WAIT:    if (cnt == '0) state_n = RESP;
      RESP:    if (resp_yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lat          <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      err_o        <= 1'b0;
    end else begin
      state <= state_n;
      if (req_yumi_o) begin
        lat <= cur;
        cnt <= CNT_INIT;
        if (cur.oor) err_o <= 1'b1;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (state != RESP && state_n == RESP) begin
        resp_valid_o <= 1'b1;
        resp_rdata_o <= rd_val;
      end else if (state == RESP && resp_yumi_i) begin
        resp_valid_o <= 1'b0;
      end
    end
  end

  // Array is not reset; stores commit on the accept edge.
  always_ff @(posedge clk) begin
    if (req_yumi_o && cur.wen && !cur.oor) begin
      if (cur.byte_op) mem[cur.idx][{cur.lane, 3'b000} +: 8] <= req_wdata_i[7:0];
      else             mem[cur.idx] <= req_wdata_i;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: latency-2 instance driven against a word-array reference model,
// plus a latency-0 instance for back-to-back handshakes.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_wen, req_byte, req_yumi, resp_valid, resp_yumi, err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        z_valid, z_wen, z_byte, z_yumi, z_resp_valid, z_resp_yumi, z_err;
  logic [31:0] z_addr, z_wdata, z_rdata;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] mem_m [1024];

  dmem_ctrl #(.ADDR_WIDTH_P(10), .LATENCY_P(2)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_wen_i(req_wen),
    .req_byte_i(req_byte), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_yumi_o(req_yumi), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_yumi_i(resp_yumi), .err_o(err));

  dmem_ctrl #(.ADDR_WIDTH_P(10), .LATENCY_P(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid_i(z_valid), .req_wen_i(z_wen),
    .req_byte_i(z_byte), .req_addr_i(z_addr), .req_wdata_i(z_wdata),
    .req_yumi_o(z_yumi), .resp_valid_o(z_resp_valid), .resp_rdata_o(z_rdata),
    .resp_yumi_i(z_resp_yumi), .err_o(z_err));

  // Reference model: byte-addressed view over a plain word array.
  function automatic logic [31:0] ref_load(input logic bt, input logic [31:0] a);
    logic [31:0] w;
    if (a[31:12] != 0) return 32'h0;
    w = mem_m[a[11:2]];
    if (bt) return (w >> (8 * a[1:0])) & 32'hFF;
    return w;
  endfunction

  function automatic void ref_store(input logic bt, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    if (a[31:12] != 0) return;
    if (bt) begin
      mask = 32'hFF << (8 * a[1:0]);
      mem_m[a[11:2]] = (mem_m[a[11:2]] & ~mask) | ((d & 32'hFF) << (8 * a[1:0]));
    end else begin
      mem_m[a[11:2]] = d;
    end
  endfunction

  // One full request/response on the latency-2 instance; returns observations only.
  task automatic txn(input logic wen, input logic bt, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold, output logic acc,
                     output int lat, output logic [31:0] rd, output logic stable,
                     output logic spur);
    lat = -1; rd = '0; stable = 1'b1; spur = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_byte = bt; req_addr = addr; req_wdata = wd;
    #1 acc = req_yumi;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin lat = c; break; end
    end
    if (lat < 0) return;
    rd = resp_rdata;
    for (int k = 0; k < hold; k++) begin
      req_valid = (k % 2 == 0);
      #1 if (req_yumi) spur = 1'b1;
      @(negedge clk);
      if (!resp_valid || resp_rdata !== rd) stable = 1'b0;
    end
    req_valid = 1'b0;
    resp_yumi = 1'b1;
    @(posedge clk);
    #1 resp_yumi = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 0; req_wen = 0; req_byte = 0; req_addr = 0; req_wdata = 0; resp_yumi = 0;
    z_valid = 0; z_wen = 0; z_byte = 0; z_addr = 0; z_wdata = 0; z_resp_yumi = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nchk++;
    if ({req_yumi, resp_valid, err, resp_rdata} !== 35'h0) begin
      nerr++; $display("FAIL reset_outs got yumi=%b valid=%b err=%b rdata=%h exp all 0",
                       req_yumi, resp_valid, err, resp_rdata);
    end
    nchk++;
    if ({z_yumi, z_resp_valid, z_err, z_rdata} !== 35'h0) begin
      nerr++; $display("FAIL reset_outs_l0 got yumi=%b valid=%b err=%b rdata=%h exp all 0",
                       z_yumi, z_resp_valid, z_err, z_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_prefill();
    logic acc, st, sp; int lat; logic [31:0] rd, d;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      txn(1'b1, 1'b0, 32'(i * 4), d, 0, acc, lat, rd, st, sp);
      ref_store(1'b0, 32'(i * 4), d);
      nchk++;
      if (acc !== 1'b1 || lat != 3 || rd !== 32'h0) begin
        nerr++; $display("FAIL prefill_sw[%0d] got acc=%b lat=%0d rdata=%h exp acc=1 lat=3 rdata=0",
                         i, acc, lat, rd);
      end
    end
  endtask

  task automatic test_word();
    logic acc, st, sp; int lat; logic [31:0] rd;
    txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, acc, lat, rd, st, sp);
    ref_store(1'b0, 32'h10, 32'hDEADBEEF);
    nchk++;
    if (acc !== 1'b1 || lat != 3 || rd !== 32'h0) begin
      nerr++; $display("FAIL sw_resp got acc=%b lat=%0d rdata=%h exp 1/3/0", acc, lat, rd);
    end
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, acc, lat, rd, st, sp);
    nchk++;
    if (lat != 3 || rd !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL lw_resp got lat=%0d rdata=%h exp 3/deadbeef", lat, rd);
    end
    @(negedge clk);
    nchk++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL after_yumi got valid=%b rdata=%h exp 0/deadbeef", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_byte();
    logic acc, st, sp; int lat; logic [31:0] rd;
    txn(1'b1, 1'b0, 32'h10, 32'h11223344, 0, acc, lat, rd, st, sp);
    ref_store(1'b0, 32'h10, 32'h11223344);
    txn(1'b1, 1'b1, 32'h13, 32'h000000AA, 0, acc, lat, rd, st, sp);
    ref_store(1'b1, 32'h13, 32'h000000AA);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, acc, lat, rd, st, sp);
    nchk++;
    if (rd !== 32'hAA223344) begin
      nerr++; $display("FAIL sb_lw got %h exp aa223344", rd);
    end
    txn(1'b0, 1'b1, 32'h12, 32'h0, 0, acc, lat, rd, st, sp);
    nchk++;
    if (rd !== 32'h00000022) begin
      nerr++; $display("FAIL lbu_lane2 got %h exp 00000022", rd);
    end
    txn(1'b0, 1'b0, 32'h11, 32'h0, 0, acc, lat, rd, st, sp);
    nchk++;
    if (rd !== 32'hAA223344) begin
      nerr++; $display("FAIL lw_misaligned got %h exp aa223344", rd);
    end
    txn(1'b1, 1'b1, 32'h14, 32'hFFFFFF5A, 0, acc, lat, rd, st, sp);
    ref_store(1'b1, 32'h14, 32'hFFFFFF5A);
    txn(1'b0, 1'b0, 32'h14, 32'h0, 0, acc, lat, rd, st, sp);
    nchk++;
    if (rd !== ref_load(1'b0, 32'h14)) begin
      nerr++; $display("FAIL sb_lane0 got %h exp %h", rd, ref_load(1'b0, 32'h14));
    end
  endtask

  task automatic test_hold();
    logic acc, st, sp; int lat; logic [31:0] rd;
    txn(1'b0, 1'b0, 32'h10, 32'h0, 5, acc, lat, rd, st, sp);
    nchk++;
    if (rd !== 32'hAA223344 || st !== 1'b1 || sp !== 1'b0) begin
      nerr++; $display("FAIL resp_hold got rdata=%h stable=%b spurious_yumi=%b exp aa223344/1/0",
                       rd, st, sp);
    end
  endtask

  task automatic test_random();
    logic acc, st, sp, wen, bt; int lat; logic [31:0] rd, a, d, exp_rd;
    for (int i = 0; i < 60; i++) begin
      wen = 1'($urandom_range(0, 1));
      bt  = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 63));
      d   = $urandom;
      exp_rd = wen ? 32'h0 : ref_load(bt, a);
      txn(wen, bt, a, d, $urandom_range(0, 2), acc, lat, rd, st, sp);
      if (wen) ref_store(bt, a, d);
      nchk++;
      if (acc !== 1'b1 || lat != 3 || rd !== exp_rd || st !== 1'b1) begin
        nerr++; $display("FAIL rand[%0d] wen=%b byte=%b addr=%h got lat=%0d rdata=%h stable=%b exp 3/%h/1",
                         i, wen, bt, a, lat, rd, st, exp_rd);
      end
    end
  endtask

  task automatic test_oor();
    logic acc, st, sp; int lat; logic [31:0] rd;
    txn(1'b1, 1'b0, 32'h00001000, 32'h5, 0, acc, lat, rd, st, sp);
    nchk++;
    if (acc !== 1'b1 || lat != 3 || rd !== 32'h0 || err !== 1'b1) begin
      nerr++; $display("FAIL oor_sw got acc=%b lat=%0d rdata=%h err=%b exp 1/3/0/1", acc, lat, rd, err);
    end
    txn(1'b0, 1'b0, 32'h0, 32'h0, 0, acc, lat, rd, st, sp);
    nchk++;
    if (rd !== mem_m[0]) begin
      nerr++; $display("FAIL oor_word0 got %h exp %h", rd, mem_m[0]);
    end
    txn(1'b0, 1'b0, 32'h00001000, 32'h0, 0, acc, lat, rd, st, sp);
    nchk++;
    if (rd !== 32'h0 || lat != 3) begin
      nerr++; $display("FAIL oor_lw got rdata=%h lat=%0d exp 0/3", rd, lat);
    end
    txn(1'b0, 1'b1, 32'h80000003, 32'h0, 0, acc, lat, rd, st, sp);
    nchk++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      nerr++; $display("FAIL oor_lbu_sticky got rdata=%h err=%b exp 0/1", rd, err);
    end
  endtask

  task automatic test_reset_mid();
    logic acc, st, sp; int lat; logic [31:0] rd;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_byte = 1'b0; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    nchk++;
    if ({req_yumi, resp_valid, err, resp_rdata} !== 35'h0) begin
      nerr++; $display("FAIL reset_in_wait got yumi=%b valid=%b err=%b rdata=%h exp all 0",
                       req_yumi, resp_valid, err, resp_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, acc, lat, rd, st, sp);
    nchk++;
    if (acc !== 1'b1 || lat != 3 || rd !== ref_load(1'b0, 32'h10) || err !== 1'b0) begin
      nerr++; $display("FAIL after_reset_lw got acc=%b lat=%0d rdata=%h err=%b exp 1/3/%h/0",
                       acc, lat, rd, err, ref_load(1'b0, 32'h10));
    end
    txn(1'b0, 1'b0, 32'h14, 32'h0, 0, acc, lat, rd, st, sp);
    nchk++;
    if (rd !== ref_load(1'b0, 32'h14)) begin
      nerr++; $display("FAIL after_reset_data got %h exp %h", rd, ref_load(1'b0, 32'h14));
    end
  endtask

  // Latency-0 instance with req_valid held high across consecutive requests.
  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    z_valid = 1'b1; z_wen = 1'b1; z_byte = 1'b0; z_addr = 32'h8; z_wdata = d;
    #1;
    nchk++;
    if (z_yumi !== 1'b1) begin
      nerr++; $display("FAIL b2b_store_accept got yumi=%b exp 1", z_yumi);
    end
    @(posedge clk);
    #1 z_wen = 1'b0;
    @(negedge clk);
    nchk++;
    if (z_resp_valid !== 1'b1 || z_rdata !== 32'h0 || z_yumi !== 1'b0) begin
      nerr++; $display("FAIL b2b_store_resp got valid=%b rdata=%h yumi=%b exp 1/0/0",
                       z_resp_valid, z_rdata, z_yumi);
    end
    z_resp_yumi = 1'b1;
    @(posedge clk);
    #1 z_resp_yumi = 1'b0;
    @(negedge clk);
    nchk++;
    if (z_resp_valid !== 1'b0 || z_yumi !== 1'b1) begin
      nerr++; $display("FAIL b2b_load_accept got valid=%b yumi=%b exp 0/1", z_resp_valid, z_yumi);
    end
    @(posedge clk);
    #1 begin z_byte = 1'b1; z_addr = 32'hA; end
    @(negedge clk);
    nchk++;
    if (z_resp_valid !== 1'b1 || z_rdata !== d) begin
      nerr++; $display("FAIL b2b_load_resp got valid=%b rdata=%h exp 1/%h", z_resp_valid, z_rdata, d);
    end
    z_resp_yumi = 1'b1;
    @(posedge clk);
    #1 z_resp_yumi = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 z_valid = 1'b0;
    @(negedge clk);
    nchk++;
    if (z_resp_valid !== 1'b1 || z_rdata !== ((d >> 16) & 32'hFF)) begin
      nerr++; $display("FAIL b2b_lbu got valid=%b rdata=%h exp 1/%h",
                       z_resp_valid, z_rdata, (d >> 16) & 32'hFF);
    end
    z_resp_yumi = 1'b1;
    @(posedge clk);
    #1 z_resp_yumi = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_word();
    test_byte();
    test_hold();
    test_random();
    test_back_to_back();
    test_oor();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
